// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared seven-segment codes, digit indices and scan phase type
package disp_pkg;

   localparam int NUM_DIGITS = 6;

   typedef logic [3:0] bcd_t;

   // Active-high {g,f,e,d,c,b,a}, bit0 = a
   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   localparam logic [2:0] IDX_SEC_L = 3'd0;
   localparam logic [2:0] IDX_SEC_H = 3'd1;
   localparam logic [2:0] IDX_MIN_L = 3'd2;
   localparam logic [2:0] IDX_MIN_H = 3'd3;
   localparam logic [2:0] IDX_HR_L  = 3'd4;
   localparam logic [2:0] IDX_HR_H  = 3'd5;

   typedef enum logic {PH_BLANK, PH_DRIVE} phase_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - BCD digit to active-high seven-segment pattern, dash for non-BCD
module bcd_to_seg7
   import disp_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/stop_watch_disp_scan.sv
// rtl/stop_watch_disp_scan.sv - six-digit multiplexed seven-segment scanner with frame snapshot
module stop_watch_disp_scan
   import disp_pkg::*;
#(
   parameter int SCAN_DIV    = 10000,
   parameter int BLANK_CYC   = 200,
   parameter int BLANK_LZ    = 1,
   parameter int SEG_ACT_LOW = 1,
   parameter int DIG_ACT_LOW = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] hr_h,
   input  logic [3:0] hr_l,
   input  logic [3:0] min_h,
   input  logic [3:0] min_l,
   input  logic [3:0] sec_h,
   input  logic [3:0] sec_l,
   output logic [6:0] seg,
   output logic       dp,
   output logic [5:0] dig_sel
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
   localparam logic [6:0] SEG_MASK = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic       DP_MASK  = (SEG_ACT_LOW != 0);
   localparam logic [NUM_DIGITS-1:0] DIG_MASK = (DIG_ACT_LOW != 0) ? '1 : '0;

   logic [CW-1:0]           cnt;
   logic [2:0]              idx;
   bcd_t                    snap [NUM_DIGITS];
   logic                    slot_end;
   logic                    frame_end;
   phase_t                  phase;
   bcd_t                    cur_bcd;
   logic [6:0]              cur_seg;
   logic                    suppress;
   logic [6:0]              seg_ah;
   logic                    dp_ah;
   logic [NUM_DIGITS-1:0]   dig_ah;

   assign slot_end  = (cnt == CNT_LAST);
   assign frame_end = slot_end && (idx == IDX_HR_H);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= IDX_SEC_L;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= (idx == IDX_HR_H) ? IDX_SEC_L : idx + 3'd1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Whole-frame sample taken as the last slot ends, so a frame never tears
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_DIGITS; i++) snap[i] <= '0;
      end else if (frame_end) begin
         snap[IDX_SEC_L] <= sec_l;
         snap[IDX_SEC_H] <= sec_h;
         snap[IDX_MIN_L] <= min_l;
         snap[IDX_MIN_H] <= min_h;
         snap[IDX_HR_L]  <= hr_l;
         snap[IDX_HR_H]  <= hr_h;
      end
   end

   always_comb begin
      cur_bcd = snap[IDX_SEC_L];
      case (idx)
         IDX_SEC_H: cur_bcd = snap[IDX_SEC_H];
         IDX_MIN_L: cur_bcd = snap[IDX_MIN_L];
         IDX_MIN_H: cur_bcd = snap[IDX_MIN_H];
         IDX_HR_L:  cur_bcd = snap[IDX_HR_L];
         IDX_HR_H:  cur_bcd = snap[IDX_HR_H];
         default:   cur_bcd = snap[IDX_SEC_L];
      endcase
   end

   bcd_to_seg7 u_dec (
      .bcd (cur_bcd),
      .seg (cur_seg)
   );

   // Only literal zeros are suppressed, so a dash always survives
   always_comb begin
      suppress = 1'b0;
      if (BLANK_LZ != 0) begin
         case (idx)
            IDX_HR_H:  suppress = (snap[IDX_HR_H] == 4'd0);
            IDX_HR_L:  suppress = (snap[IDX_HR_H] == 4'd0) && (snap[IDX_HR_L] == 4'd0);
            IDX_MIN_H: suppress = (snap[IDX_HR_H] == 4'd0) && (snap[IDX_HR_L] == 4'd0)
                                  && (snap[IDX_MIN_H] == 4'd0);
            default:   suppress = 1'b0;
         endcase
      end
   end

   always_comb begin
      phase  = (cnt < CNT_BLANK) ? PH_BLANK : PH_DRIVE;
      seg_ah = SEG_OFF;
      dp_ah  = 1'b0;
      dig_ah = '0;
      if (phase == PH_DRIVE) begin
         dig_ah = NUM_DIGITS'(1) << idx;
         seg_ah = suppress ? SEG_OFF : cur_seg;
         dp_ah  = (idx == IDX_MIN_L) || (idx == IDX_HR_L);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg     <= SEG_MASK;
         dp      <= DP_MASK;
         dig_sel <= DIG_MASK;
      end else begin
         seg     <= seg_ah ^ SEG_MASK;
         dp      <= dp_ah ^ DP_MASK;
         dig_sel <= dig_ah ^ DIG_MASK;
      end
   end

endmodule

// File: doc/stop_watch_disp_scan.md
# stop_watch_disp_scan

Time-multiplexed six-digit seven-segment display driver placed directly downstream of `stop_watch`. It consumes the six BCD digits (`hr_h` … `sec_l`) and drives one shared segment bus plus six digit enables on the 10 MHz board clock. It captures a tear-free snapshot of all six digits once per frame, inserts an anti-ghosting blank gap before each digit, optionally suppresses leading zeros, and lights decimal points as hh.mm.ss separators.

## Interface
- `SCAN_DIV`, 10000 — clk cycles per digit slot (1 kHz slot rate, ≈167 Hz frame); constraint SCAN_DIV ≥ BLANK_CYC+2.
- `BLANK_CYC`, 200 — cycles at slot start with all digits off; constraint ≥1.
- `BLANK_LZ`, 1 — 1 enables leading-zero suppression.
- `SEG_ACT_LOW`, 1 — 1: `seg`/`dp` are active-low.
- `DIG_ACT_LOW`, 1 — 1: `dig_sel` is active-low.
- Reset `rst_n`, asynchronous, active-low; clock `clk`.
- `clk`  in  1  10 MHz system clock.
- `rst_n`  in  1  async reset, active-low.
- `hr_h, hr_l, min_h, min_l, sec_h, sec_l`  in  4 each  BCD digits from `stop_watch`, synchronous to `clk`.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, bit0 = a.
- `dp`  out  1  decimal point.
- `dig_sel`  out  6  digit enables; bit0 = sec_l … bit5 = hr_h.

## Operation
- Slot counter `cnt` runs 0..SCAN_DIV-1. On `cnt == SCAN_DIV-1`, `cnt` returns to 0 and digit index `idx` advances 0→1→…→5→0. `idx` 0 = sec_l, 1 = sec_h, 2 = min_l, 3 = min_h, 4 = hr_l, 5 = hr_h.
- The snapshot register (6×4 bits) loads all six inputs on the edge where `cnt == SCAN_DIV-1` and `idx == 5`. A frame is therefore always displayed from one coherent sample, and input changes mid-frame are invisible until the next frame.
- Two per-slot phases are derived from `cnt`:
  - BLANK (`cnt < BLANK_CYC`): all `dig_sel` inactive, `seg` all off, `dp` off.
  - DRIVE (`cnt ≥ BLANK_CYC`): `dig_sel` bit `idx` active, others inactive.
- Decode, in active-high terms before polarity inversion:
  - Codes: 0=7'h3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any value >9 shows a dash, 7'h40.
- Leading-zero suppression (BLANK_LZ = 1):
  - hr_h is blank if 0.
  - hr_l is blank if hr_h == 0 and hr_l == 0.
  - min_h is blank if hr_h, hr_l and min_h are all 0.
  - min_l, sec_h and sec_l are never suppressed.
  - A suppressed digit keeps its `dig_sel` active with `seg` all off.
  - A dash is never suppressed.
- `dp` is on during DRIVE for `idx` 2 (min_l) and `idx` 4 (hr_l), regardless of blanking.
- Polarity is applied last, per SEG_ACT_LOW / DIG_ACT_LOW.

## Timing
- All outputs are registered. Pins reflect the `cnt`/`idx` of the previous cycle, so each digit is active for exactly SCAN_DIV−BLANK_CYC consecutive cycles per frame, delayed one clk.
- Frame length is 6·SCAN_DIV cycles. The snapshot is used starting at the slot after it is captured.
- Reset values:
  - `cnt` = 0, `idx` = 0, snapshot = 0.
  - `dig_sel` all inactive, `seg` all off, `dp` off (in pin polarity).
- After `rst_n` rises, the first frame displays snapshot zeros; with BLANK_LZ = 1 that reads "0.00" on min_l, sec_h, sec_l.
- Reset asserted mid-slot forces the reset values immediately (asynchronously). No digit stays lit.
- Two digits are never active in the same cycle. At least BLANK_CYC dark cycles separate consecutive digits.

## Structure
- Shared package `disp_pkg`:
  - seg7 code constants SEG_0..SEG_9 and SEG_DASH.
  - Digit index localparams IDX_SEC_L..IDX_HR_H.
  - NUM_DIGITS = 6.
- One combinational sub-module, `bcd_to_seg7` (4-bit in → 7-bit active-high out, dash for >9), instantiated once on the muxed snapshot digit.
- The counter, snapshot, blanking logic and output registers live in the top module.

## Test plan
Directed tests use SCAN_DIV = 8, BLANK_CYC = 2 and active-high polarity unless stated.

1. Reset check: hold `rst_n` = 0 → `dig_sel` = 0, `seg` = 0, `dp` = 0. Release → 2 dark cycles, then `dig_sel` = 6'b000001 with `seg` = 7'h3F for 6 cycles.
2. Static 12:34:56 → per slot:
   - sec_l: 7'h7D
   - sec_h: 7'h6D
   - min_l: 7'h66, `dp` = 1
   - min_h: 7'h4F
   - hr_l: 7'h5B, `dp` = 1
   - hr_h: 7'h06
   - Each digit is lit 6 of 8 cycles, never overlapping.
3. Tear test: inputs change from 12:34:56 to 12:34:57 during `idx` = 2 → the remainder of the frame still shows 6 on sec_l; the next frame shows 7 (7'h07).
4. Leading zeros 00:05:07 with BLANK_LZ = 1 → hr_h, hr_l, min_h have `dig_sel` active and `seg` = 0; min_l `seg` = 7'h6D; hr_l `dp` still 1. With BLANK_LZ = 0 → those three digits show 7'h3F.
5. Invalid BCD: hr_h = 4'hA → `seg` = 7'h40 on `dig_sel[5]`. With SEG_ACT_LOW = 1 → 7'h3F on the pins.
6. Reset mid-slot (`idx` = 3, `cnt` = 5) → outputs go inactive in the same cycle. After release, the scan restarts at `idx` 0 with snapshot 0.
